// File: rtl/scs8hd_addcon_pkg.sv
// Shared configuration helpers for the pipelined adder/subtractor.
package scs8hd_addcon_pkg;

    // COUTN idles high: "no carry" is the quiescent state of the inverted carry.
    localparam logic COUTN_RST = 1'b1;

    // Number of registered slices the add is split into.
    function automatic int calc_stages(input int width, input int lane);
        return width / lane;
    endfunction

    // Legal geometry: at least one lane, lane fits the word, word is whole lanes.
    function automatic bit cfg_ok(input int width, input int lane);
        return (lane >= 1) && (lane <= width) && ((width % lane) == 0);
    endfunction

endpackage

// File: rtl/scs8hd_addcon_slice.sv
// One LANE-bit ripple slice: adds its operand bits with the registered carry
// from the previous slice and registers sum, inverted carry, overflow and valid.
module scs8hd_addcon_slice
    import scs8hd_addcon_pkg::*;
#(
    parameter int LANE = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            advance,
    input  logic            vld_in,
    input  logic            cin,
    input  logic [LANE-1:0] a,
    input  logic [LANE-1:0] b,
    output logic [LANE-1:0] sum_p,
    output logic            coutn_p,
    output logic            ovf_p,
    output logic            vld_p
);

    logic [LANE:0] total;
    logic          c_msb;

    assign total = {1'b0, a} + {1'b0, b} + {{LANE{1'b0}}, cin};
    // Carry into the slice MSB recovered from the MSB sum bit.
    assign c_msb = a[LANE-1] ^ b[LANE-1] ^ total[LANE-1];

    // Valid bit advances with the global pipeline enable; bubbles shift in too.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p <= 1'b0;
        end else if (advance) begin
            vld_p <= vld_in;
        end
    end

    // Result bits only update for real beats so outputs stay quiet across bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_p   <= '0;
            coutn_p <= COUTN_RST;
            ovf_p   <= 1'b0;
        end else if (advance && vld_in) begin
            sum_p   <= total[LANE-1:0];
            coutn_p <= ~total[LANE];
            ovf_p   <= c_msb ^ total[LANE];
        end
    end

endmodule

// File: rtl/scs8hd_addcon_pipe.sv
// Pipelined ripple-carry adder/subtractor with active-low carry out.
// Operand bits above the active slice are skewed forward and finished sum
// bits below it are carried forward, so each beat emerges aligned.
module scs8hd_addcon_pipe
    import scs8hd_addcon_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANE  = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             COUTN,
    output logic             OVF
);

    localparam int STAGES = calc_stages(WIDTH, LANE);
    localparam int LAST   = STAGES - 1;

    if (!cfg_ok(WIDTH, LANE)) begin : g_cfg_err
        $fatal(1, "scs8hd_addcon_pipe: WIDTH must be a non-zero multiple of LANE");
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;

    // Whole pipe moves together; only a held, unconsumed result stalls it.
    assign advance  = OUT_READY || !OUT_VALID;
    assign IN_READY = advance;
    assign b_eff    = SUB ? ~B : B;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int HW = WIDTH - (k + 1) * LANE;
        localparam int LW = k * LANE;

        logic [LANE-1:0] a_k;
        logic [LANE-1:0] b_k;
        logic            cin_k;
        logic            vin_k;
        logic            load_k;
        logic [LANE-1:0] sum_p;
        logic            coutn_p;
        logic            ovf_p;
        logic            vld_p;

        if (k == 0) begin : g_in
            assign a_k   = A[LANE-1:0];
            assign b_k   = b_eff[LANE-1:0];
            assign cin_k = SUB | CI;
            assign vin_k = IN_VALID;
        end else begin : g_in
            assign a_k   = g_stage[k-1].g_hi.a_hi[LANE-1:0];
            assign b_k   = g_stage[k-1].g_hi.b_hi[LANE-1:0];
            assign cin_k = ~g_stage[k-1].coutn_p;
            assign vin_k = g_stage[k-1].vld_p;
        end

        assign load_k = advance && vin_k;

        scs8hd_addcon_slice #(.LANE(LANE)) u_slice (
            .clk     (CLK),
            .reset   (RESET),
            .advance (advance),
            .vld_in  (vin_k),
            .cin     (cin_k),
            .a       (a_k),
            .b       (b_k),
            .sum_p   (sum_p),
            .coutn_p (coutn_p),
            .ovf_p   (ovf_p),
            .vld_p   (vld_p)
        );

        if (HW > 0) begin : g_hi
            logic [HW-1:0] a_src;
            logic [HW-1:0] b_src;
            logic [HW-1:0] a_hi;
            logic [HW-1:0] b_hi;

            if (k == 0) begin : g_src
                assign a_src = A[WIDTH-1:LANE];
                assign b_src = b_eff[WIDTH-1:LANE];
            end else begin : g_src
                assign a_src = g_stage[k-1].g_hi.a_hi[HW+LANE-1:LANE];
                assign b_src = g_stage[k-1].g_hi.b_hi[HW+LANE-1:LANE];
            end

            // Skew: operand bits not yet added travel with their beat.
            always_ff @(posedge CLK) begin
                if (load_k) begin
                    a_hi <= a_src;
                    b_hi <= b_src;
                end
            end
        end

        if (k > 0) begin : g_lo
            logic [LW-1:0] lo_src;
            logic [LW-1:0] lo;

            if (k == 1) begin : g_src
                assign lo_src = g_stage[0].sum_p;
            end else begin : g_src
                assign lo_src = {g_stage[k-1].sum_p, g_stage[k-1].g_lo.lo};
            end

            // Deskew: finished low sum bits travel with their beat; they reach SUM.
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    lo <= '0;
                end else if (load_k) begin
                    lo <= lo_src;
                end
            end
        end
    end

    if (STAGES == 1) begin : g_sum
        assign SUM = g_stage[0].sum_p;
    end else begin : g_sum
        assign SUM = {g_stage[LAST].sum_p, g_stage[LAST].g_lo.lo};
    end

    assign OUT_VALID = g_stage[LAST].vld_p;
    assign COUTN     = g_stage[LAST].coutn_p;
    assign OVF       = g_stage[LAST].ovf_p;

endmodule

// File: tb/tb_scs8hd_addcon_pipe.sv
// Directed bench for scs8hd_addcon_pipe (WIDTH=16, LANE=4).
module tb_scs8hd_addcon_pipe;

    localparam int WIDTH  = 16;
    localparam int LANE   = 4;
    localparam int STAGES = WIDTH / LANE;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CI;
    logic             SUB;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] SUM;
    logic             COUTN;
    logic             OVF;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 CLK = ~CLK;

    scs8hd_addcon_pipe #(.WIDTH(WIDTH), .LANE(LANE)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .CI        (CI),
        .SUB       (SUB),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .SUM       (SUM),
        .COUTN     (COUTN),
        .OVF       (OVF)
    );

    // Offer one beat, then count edges until its result appears (bounded).
    task automatic send_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic ci, input logic sub, output int lat);
        A = a; B = b; CI = ci; SUB = sub; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        lat = 0;
        while (!OUT_VALID && lat < 20) begin
            @(posedge CLK); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        int seen;
        RESET = 1'b1; OUT_READY = 1'b1;
        IN_VALID = 1'b1; A = 16'h1111; B = 16'h2222; CI = 1'b0; SUB = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        tests_run++; if (OUT_VALID !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b expected 0", OUT_VALID); end
        tests_run++; if (SUM !== 16'h0000) begin tests_failed++; $display("FAIL reset_sum got %h expected 0000", SUM); end
        tests_run++; if (COUTN !== 1'b1) begin tests_failed++; $display("FAIL reset_coutn got %b expected 1", COUTN); end
        tests_run++; if (OVF !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got %b expected 0", OVF); end
        tests_run++; if (IN_READY !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b expected 1", IN_READY); end
        RESET = 1'b0; IN_VALID = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK); #1;
            if (OUT_VALID) seen++;
        end
        tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL reset_beat_dropped got %0d results expected 0", seen); end
    endtask

    task automatic test_arith(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic ci, input logic sub,
                              input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        int lat;
        send_one(a, b, ci, sub, lat);
        tests_run++; if (lat !== STAGES - 1) begin tests_failed++; $display("FAIL %s latency got %0d expected %0d", name, lat, STAGES - 1); end
        tests_run++; if (SUM !== es) begin tests_failed++; $display("FAIL %s sum got %h expected %h", name, SUM, es); end
        tests_run++; if (COUTN !== ec) begin tests_failed++; $display("FAIL %s coutn got %b expected %b", name, COUTN, ec); end
        tests_run++; if (OVF !== eo) begin tests_failed++; $display("FAIL %s ovf got %b expected %b", name, OVF, eo); end
        @(posedge CLK); #1;
    endtask

    task automatic test_carry_ripple();
        test_arith("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        test_arith("add_ci", 16'h1234, 16'h0F0F, 1'b1, 1'b0, 16'h2144, 1'b1, 1'b0);
    endtask

    task automatic test_subtract();
        test_arith("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0);
        test_arith("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
        test_arith("sub_ci_ign", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        test_arith("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1);
        test_arith("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    endtask

    task automatic test_back_pressure();
        int sent, rcv, stalls, bad_ready, extra;
        logic in_fire, out_fire, exp_ready;
        logic [WIDTH-1:0] exp_sum;
        sent = 0; rcv = 0; stalls = 0; bad_ready = 0; extra = 0;
        CI = 1'b0; SUB = 1'b0;
        for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
            OUT_READY = !(cyc >= 5 && cyc <= 7);
            IN_VALID  = (sent < 8);
            A = 16'(sent);
            B = 16'(sent * 16'h0100);
            #1;
            exp_ready = !(OUT_VALID && !OUT_READY);
            if (IN_READY !== exp_ready) bad_ready++;
            if (!IN_READY) stalls++;
            in_fire  = IN_VALID && IN_READY;
            out_fire = OUT_VALID && OUT_READY;
            if (out_fire) begin
                exp_sum = 16'(rcv * 16'h0101);
                tests_run++; if (SUM !== exp_sum) begin tests_failed++; $display("FAIL bp_result%0d got %h expected %h", rcv, SUM, exp_sum); end
                rcv++;
            end
            @(posedge CLK); #1;
            if (in_fire) sent++;
        end
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        tests_run++; if (rcv !== 8) begin tests_failed++; $display("FAIL bp_count got %0d expected 8", rcv); end
        tests_run++; if (bad_ready !== 0) begin tests_failed++; $display("FAIL bp_in_ready got %0d wrong cycles expected 0", bad_ready); end
        tests_run++; if (stalls !== 3) begin tests_failed++; $display("FAIL bp_stall_cycles got %0d expected 3", stalls); end
        for (int i = 0; i < 6; i++) begin
            if (OUT_VALID) extra++;
            @(posedge CLK); #1;
        end
        tests_run++; if (extra !== 0) begin tests_failed++; $display("FAIL bp_duplicate got %0d extra expected 0", extra); end
    endtask

    task automatic test_reset_midflight();
        int lat;
        OUT_READY = 1'b1; CI = 1'b0; SUB = 1'b0;
        for (int i = 0; i < 3; i++) begin
            A = 16'(16'h0100 * (i + 1)); B = 16'h0022; IN_VALID = 1'b1;
            @(posedge CLK); #1;
        end
        IN_VALID = 1'b0; RESET = 1'b1;
        @(posedge CLK); #1;
        tests_run++; if (OUT_VALID !== 1'b0) begin tests_failed++; $display("FAIL midrst_out_valid got %b expected 0", OUT_VALID); end
        RESET = 1'b0;
        send_one(16'h0ABC, 16'h0001, 1'b0, 1'b0, lat);
        tests_run++; if (lat !== STAGES - 1) begin tests_failed++; $display("FAIL midrst_latency got %0d expected %0d", lat, STAGES - 1); end
        tests_run++; if (SUM !== 16'h0ABD) begin tests_failed++; $display("FAIL midrst_sum got %h expected 0abd", SUM); end
        @(posedge CLK); #1;
    endtask

    initial begin
        test_reset();
        test_carry_ripple();
        test_subtract();
        test_overflow();
        test_back_pressure();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
